// File: rtl/sprite_mem.sv
// Multi-slot sprite texel RAM with a streaming slot loader; reads return data 1 cycle after rd_en.
// Loader backpressure: load_ready is high only while loading a slot; load_valid=0 stalls it.
module sprite_mem #(
    parameter int CHANNEL_BITS = 2,
    parameter int TEX_BITS     = 6,
    parameter int SPRITES      = 4,
    parameter int SID_BITS     = (SPRITES > 1) ? $clog2(SPRITES) : 1,
    parameter logic [CHANNEL_BITS*3-1:0] KEY_COLOR = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_en,
    input  logic [SID_BITS-1:0]       rd_sprite,
    input  logic [TEX_BITS-1:0]       col,
    input  logic [TEX_BITS-1:0]       row,
    output logic [CHANNEL_BITS*3-1:0] val,
    output logic                      val_valid,
    output logic                      transparent,
    input  logic                      load_start,
    input  logic [SID_BITS-1:0]       load_sprite,
    input  logic [CHANNEL_BITS*3-1:0] load_data,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic                      load_busy,
    output logic                      load_done
);
    localparam int W      = CHANNEL_BITS * 3;
    localparam int TEXELS = 1 << (2 * TEX_BITS);
    localparam int DEPTH  = SPRITES * TEXELS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2*TEX_BITS-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } load_state_t;

    logic [W-1:0] mem [DEPTH];

    load_state_t             state, state_nxt;
    logic [2*TEX_BITS-1:0]   addr, addr_nxt;
    logic [SID_BITS-1:0]     slot, slot_nxt;
    logic                    we;
    logic                    rd_hit;
    logic [MEM_AW-1:0]       rd_addr;
    logic [MEM_AW-1:0]       wr_addr;

    // Slot index sits above {col,row}; in-range slots never set bits past MEM_AW.
    assign rd_hit  = (int'(rd_sprite) < SPRITES);
    assign rd_addr = MEM_AW'({rd_sprite, col, row});
    assign wr_addr = MEM_AW'({slot, addr});

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val         <= '0;
            val_valid   <= 1'b0;
            transparent <= 1'b0;
        end else begin
            val_valid <= rd_en;
            if (rd_en) begin
                if (rd_hit) begin
                    val         <= mem[rd_addr];
                    transparent <= (mem[rd_addr] == KEY_COLOR);
                end else begin
                    val         <= '0;
                    transparent <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            slot  <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        slot_nxt   = slot;
        we         = 1'b0;
        load_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start && (int'(load_sprite) < SPRITES)) begin
                    slot_nxt  = load_sprite;
                    addr_nxt  = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                if (load_valid) begin
                    we = 1'b1;
                    // Terminal texel ends the slot; the counter never rolls into the next slot.
                    if (addr == '1) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt = addr + ADDR_ONE;
                    end
                end
            end
            DONE: begin
                load_done = 1'b1;
                load_busy = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sprite_mem.sv
// Bench for sprite_mem: small slot config, randomized loads checked against a per-slot texel array.
`timescale 1ns/1ps
module tb_sprite_mem;
    localparam int CB = 2;
    localparam int TB = 2;
    localparam int NS = 2;
    localparam int SB = 2;
    localparam int W  = 6;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_en;
    logic [SB-1:0] rd_sprite;
    logic [TB-1:0] col;
    logic [TB-1:0] row;
    logic [W-1:0]  val;
    logic          val_valid;
    logic          transparent;
    logic          load_start;
    logic [SB-1:0] load_sprite;
    logic [W-1:0]  load_data;
    logic          load_valid;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model [0:NS-1][0:NT-1];
    logic [W-1:0] ldata [0:NT-1];

    sprite_mem #(
        .CHANNEL_BITS(CB),
        .TEX_BITS(TB),
        .SPRITES(NS),
        .SID_BITS(SB),
        .KEY_COLOR(6'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_en(rd_en),
        .rd_sprite(rd_sprite),
        .col(col),
        .row(row),
        .val(val),
        .val_valid(val_valid),
        .transparent(transparent),
        .load_start(load_start),
        .load_sprite(load_sprite),
        .load_data(load_data),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_busy(load_busy),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_val(input int s, input int k);
        if (s < NS) return model[s][k];
        return '0;
    endfunction

    task automatic do_read(input int s, input int c, input int r);
        logic [W-1:0] e;
        logic         te;
        int           k;
        k  = c * 4 + r;
        e  = exp_val(s, k);
        te = (s >= NS) || (e == 6'h00);
        rd_en = 1'b1; rd_sprite = s[SB-1:0]; col = c[TB-1:0]; row = r[TB-1:0];
        step();
        rd_en = 1'b0;
        n_checks++;
        if (val_valid !== 1'b1 || val !== e || transparent !== te) begin
            n_fail++;
            $display("FAIL read s%0d c%0d r%0d: valid=%b val=%h tr=%b, want 1 %h %b", s, c, r, val_valid, val, transparent, e, te);
        end
        step();
        n_checks++;
        if (val_valid !== 1'b0 || val !== e || transparent !== te) begin
            n_fail++;
            $display("FAIL read_hold s%0d: valid=%b val=%h tr=%b, want 0 %h %b", s, val_valid, val, transparent, e, te);
        end
    endtask

    // Back-to-back reads of a whole slot, descending texel order.
    task automatic test_readback(input int s);
        logic [W-1:0] e;
        int           k;
        e = '0;
        for (int i = 0; i < NT; i++) begin
            k = NT - 1 - i;
            rd_en = 1'b1; rd_sprite = s[SB-1:0]; col = k[3:2]; row = k[1:0];
            step();
            e = exp_val(s, k);
            n_checks++;
            if (val_valid !== 1'b1 || val !== e || transparent !== (e == 6'h00)) begin
                n_fail++;
                $display("FAIL readback s%0d k%0d: valid=%b val=%h tr=%b, want 1 %h %b", s, k, val_valid, val, transparent, e, (e == 6'h00));
            end
        end
        rd_en = 1'b0;
        step();
        n_checks++;
        if (val_valid !== 1'b0 || val !== e) begin
            n_fail++;
            $display("FAIL readback_idle s%0d: valid=%b val=%h, want 0 %h", s, val_valid, val, e);
        end
    endtask

    // mode 0: load_valid always 1, mode 1: toggling 1,0,..., mode 2: random.
    task automatic run_load(input int slot, input int mode, input int abort_after, input int rdw_idx);
        int           k;
        int           cyc;
        bit           v;
        bit           rd_pend;
        logic [W-1:0] old;
        k = 0; cyc = 0; old = '0;
        load_start = 1'b1; load_sprite = slot[SB-1:0]; load_valid = 1'b0;
        step();
        load_start = 1'b0;
        n_checks++;
        if (load_busy !== 1'b1 || load_ready !== 1'b1 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_enter: busy=%b ready=%b done=%b, want 1 1 0", load_busy, load_ready, load_done);
        end
        while (k < NT && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            load_valid  = v;
            load_data   = ldata[k];
            load_start  = (cyc == 3);
            load_sprite = (slot == 0) ? 2'd1 : 2'd0;
            rd_pend = v && (k == rdw_idx);
            if (rd_pend) begin
                rd_en = 1'b1; rd_sprite = slot[SB-1:0]; col = k[3:2]; row = k[1:0];
                old = model[slot][k];
            end
            step();
            rd_en = 1'b0; load_start = 1'b0; load_valid = 1'b0;
            if (v) begin
                model[slot][k] = ldata[k];
                k++;
            end
            cyc++;
            if (rd_pend) begin
                n_checks++;
                if (val_valid !== 1'b1 || val !== old) begin
                    n_fail++;
                    $display("FAIL rdw_old: valid=%b val=%h, want 1 %h", val_valid, val, old);
                end
            end
            if (k == abort_after) begin
                #2 reset = 1'b1;
                #1;
                n_checks++;
                if (load_busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_reset: busy=%b ready=%b done=%b, want 0 0 0", load_busy, load_ready, load_done);
                end
                #2 reset = 1'b0;
                return;
            end
            n_checks++;
            if (k < NT) begin
                if (load_busy !== 1'b1 || load_ready !== 1'b1 || load_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_active k%0d: busy=%b ready=%b done=%b, want 1 1 0", k, load_busy, load_ready, load_done);
                end
            end else if (load_busy !== 1'b1 || load_ready !== 1'b0 || load_done !== 1'b1) begin
                n_fail++;
                $display("FAIL load_done_pulse: busy=%b ready=%b done=%b, want 1 0 1", load_busy, load_ready, load_done);
            end
        end
        if (k < NT) begin
            n_checks++; n_fail++;
            $display("FAIL load_timeout: %0d texels accepted, want %0d", k, NT);
            return;
        end
        if (mode == 0 || mode == 1) begin
            n_checks++;
            if (cyc != ((mode == 0) ? 16 : 31)) begin
                n_fail++;
                $display("FAIL load_cycles: %0d, want %0d", cyc, (mode == 0) ? 16 : 31);
            end
        end
        step();
        n_checks++;
        if (load_busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle: busy=%b ready=%b done=%b, want 0 0 0", load_busy, load_ready, load_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_en = 1'b0; rd_sprite = '0; col = '0; row = '0;
        load_start = 1'b0; load_sprite = '0; load_data = '0; load_valid = 1'b0;
        step(); step();
        n_checks++;
        if (val !== 6'h00 || val_valid !== 1'b0 || transparent !== 1'b0 ||
            load_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: val=%h vv=%b tr=%b rdy=%b busy=%b done=%b, want all 0", val, val_valid, transparent, load_ready, load_busy, load_done);
        end
        reset = 1'b0;
        load_valid = 1'b1;
        step(); step();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0 || load_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: rdy=%b busy=%b, want 0 0", load_ready, load_busy);
        end
    endtask

    task automatic test_basic_load();
        for (int i = 0; i < NT; i++) ldata[i] = 6'(i + 1);
        run_load(1, 0, -1, -1);
        do_read(1, 2, 3);
        n_checks++;
        if (val !== 6'h0C || transparent !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_texel: val=%h tr=%b, want 0c 0", val, transparent);
        end
        test_readback(1);
    endtask

    task automatic test_transparency();
        for (int i = 0; i < NT; i++) ldata[i] = 6'h00;
        ldata[5] = 6'h3F;
        run_load(0, 0, -1, -1);
        do_read(0, 1, 1);
        n_checks++;
        if (val !== 6'h3F || transparent !== 1'b0) begin
            n_fail++;
            $display("FAIL opaque_texel: val=%h tr=%b, want 3f 0", val, transparent);
        end
        do_read(0, 0, 0);
        do_read(3, 1, 1);
        n_checks++;
        if (val !== 6'h00 || transparent !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_slot: val=%h tr=%b, want 00 1", val, transparent);
        end
    endtask

    task automatic test_throttled();
        for (int i = 0; i < NT; i++) ldata[i] = 6'($urandom);
        run_load(1, 1, -1, -1);
        test_readback(1);
        test_readback(0);
        for (int i = 0; i < NT; i++) ldata[i] = 6'($urandom);
        run_load(1, 2, -1, -1);
        test_readback(1);
    endtask

    task automatic test_read_during_write();
        for (int i = 0; i < NT; i++) ldata[i] = 6'($urandom);
        ldata[3] = 6'h05;
        run_load(0, 2, -1, -1);
        ldata[3] = 6'h2A;
        run_load(0, 0, -1, 3);
        do_read(0, 0, 3);
        n_checks++;
        if (val !== 6'h2A) begin
            n_fail++;
            $display("FAIL rdw_new: val=%h, want 2a", val);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < NT; i++) ldata[i] = 6'($urandom);
        run_load(1, 0, 5, -1);
        load_valid = 1'b1; load_data = ~ldata[5];
        step(); step();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0 || load_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: rdy=%b busy=%b, want 0 0", load_ready, load_busy);
        end
        test_readback(1);
        for (int i = 0; i < NT; i++) ldata[i] = 6'($urandom);
        run_load(1, 2, -1, -1);
        test_readback(1);
    endtask

    task automatic test_reset_midrun();
        do_read(0, 0, 3);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (val !== 6'h00 || val_valid !== 1'b0 || transparent !== 1'b0 ||
            load_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: val=%h vv=%b tr=%b rdy=%b busy=%b done=%b, want all 0", val, val_valid, transparent, load_ready, load_busy, load_done);
        end
        #2 reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_transparency();
        test_throttled();
        test_read_during_write();
        test_abort();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
